alu_pipe: RTL

Parametrised, pipelined successor to the 32-bit combinational ALU, keeping its 3-bit command encoding and flag set (carry, overflow, zero). It adds a two-stage registered datapath with valid/ready handshakes on both sides, so it can sit between an operand-fetch stage and a writeback stage without combinational paths crossing the block. It also makes WIDTH configurable and returns a true signed SLT.

---
 rtl/alu_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Optional sticky overflow flag is built when ALU_PIPE_STICKY_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryflag,
  output logic             overflag,
`ifdef ALU_PIPE_STICKY_EN
  output logic             sticky_ovf,
  input  logic             sticky_clr,
`endif
  output logic             zero
);

  typedef enum logic [2:0] {
    RES_ARITH = 3'd0,
    RES_SLT   = 3'd1,
    RES_XOR   = 3'd2,
    RES_AND   = 3'd3,
    RES_NAND  = 3'd4,
    RES_NOR   = 3'd5,
    RES_OR    = 3'd6
  } res_sel_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  res_sel_e         sel_q, sel_d;
  logic             inv_b_q, inv_b_d, cin_q, cin_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  logic             s1_advance, s1_load;
  logic [WIDTH-1:0] b_eff, res;
  logic [WIDTH:0]   sum;
  logic             msb_cin, add_ovf, res_carry, res_ovf;

  // Handshake control: S2 takes S1 when empty or draining, S1 refills in the same cycle.
  always_comb begin
    s1_advance = s1_valid_q & (~out_valid_q | out_ready);
    in_ready   = ~reset & (~s1_valid_q | s1_advance);
    s1_load    = in_valid & in_ready;
  end

  // Stage 1 capture and command decode.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    inv_b_d    = inv_b_q;
    cin_d      = cin_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      inv_b_d    = 1'b0;
      cin_d      = 1'b0;
      case (selector)
        3'd0: sel_d = RES_ARITH;
        3'd1: begin sel_d = RES_ARITH; inv_b_d = 1'b1; cin_d = 1'b1; end
        3'd2: sel_d = RES_XOR;
        3'd3: begin sel_d = RES_SLT; inv_b_d = 1'b1; cin_d = 1'b1; end
        3'd4: sel_d = RES_AND;
        3'd5: sel_d = RES_NAND;
        3'd6: sel_d = RES_NOR;
        3'd7: sel_d = RES_OR;
        default: sel_d = RES_ARITH;
      endcase
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 compute: one shared adder serves ADD, SUB and SLT.
  always_comb begin
    b_eff     = inv_b_q ? ~b_q : b_q;
    sum       = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
    msb_cin   = a_q[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    add_ovf   = msb_cin ^ sum[WIDTH];
    res       = {WIDTH{1'b0}};
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (sel_q)
      RES_ARITH: begin res = sum[WIDTH-1:0]; res_carry = sum[WIDTH]; res_ovf = add_ovf; end
      RES_SLT:   begin res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf}; res_ovf = add_ovf; end
      RES_XOR:   res = a_q ^ b_q;
      RES_AND:   res = a_q & b_q;
      RES_NAND:  res = ~(a_q & b_q);
      RES_NOR:   res = ~(a_q | b_q);
      RES_OR:    res = a_q | b_q;
      default:   res = {WIDTH{1'b0}};
    endcase
  end

  // Stage 2 next state: results hold while the downstream stalls.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      out_d       = res;
      carry_d     = res_carry;
      ovf_d       = res_ovf;
      zero_d      = (res == {WIDTH{1'b0}});
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sel_q       <= RES_ARITH;
      inv_b_q     <= 1'b0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      inv_b_q     <= inv_b_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carryflag = carry_q;
  assign overflag  = ovf_q;
  assign zero      = zero_q;

`ifdef ALU_PIPE_STICKY_EN
  logic sticky_q, sticky_d;

  // Setting on an overflowing output handshake beats a same-cycle clear.
  always_comb begin
    if (out_valid_q & out_ready & ovf_q) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule
